// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder
// Burst-read front end for the video fetch path. A burst request (address,
// length) is turned into a stream of single-word reads on the pipelined
// memory port. Returned words are forwarded one strobe per word, in order.
// A single pending slot queues one request that arrives while a burst runs.
// Optional feature: define SDRAM_BURST_TIMEOUT_EN to enable a watchdog that
// flushes a stalled burst with zero words and raises a sticky timeout flag.
module sdram_burst_responder #(
  parameter int ADDR_WIDTH      = 23,
  parameter int DATA_WIDTH      = 32,
  parameter int BURST_WIDTH     = 9,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_request,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [BURST_WIDTH-1:0] rd_burst_length,
  output logic                  rd_available,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  mem_rd_request,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_data
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sdram_burst_responder: MAX_OUTSTANDING must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]             state;
  logic [BURST_WIDTH-1:0] burst_len;
  logic [BURST_WIDTH-1:0] issued;
  logic [BURST_WIDTH-1:0] received;
  logic [OUT_W-1:0]       outstanding;

  logic                   pending_valid;
  logic [ADDR_WIDTH-1:0]  pending_address;
  logic [BURST_WIDTH-1:0] pending_length;

  logic                   flush_active;

  logic                   accept;
  logic                   ret;
  logic                   req_ok;
  logic                   burst_done;
  logic                   start_pending;
  logic                   start_request;
  logic                   launch;
  logic [ADDR_WIDTH-1:0]  launch_address;
  logic [BURST_WIDTH-1:0] launch_length;
  logic [OUT_W-1:0]       outstanding_next;
  logic [BURST_WIDTH-1:0] issued_next;

  assign busy = (state != IDLE);

  // Handshake decode, counter look-ahead and selection of the next burst to start
  always_comb begin
    accept           = mem_rd_request && mem_ready;
    ret              = mem_valid && (outstanding != '0) && !flush_active;
    req_ok           = rd_request && (rd_burst_length != '0);
    burst_done       = (state == DRAIN) && (received == burst_len);
    outstanding_next = outstanding + OUT_W'(accept) - OUT_W'(ret);
    issued_next      = issued + BURST_WIDTH'(accept);
    start_pending    = pending_valid && ((state == IDLE) || burst_done);
    start_request    = (state == IDLE) && !pending_valid && req_ok;
    launch           = start_pending || start_request;
    launch_address   = start_pending ? pending_address : rd_address;
    launch_length    = start_pending ? pending_length  : rd_burst_length;
  end

`ifdef SDRAM_BURST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_count;
  logic            flush;
  logic            wd_counting;
  logic            wd_expire;

  assign flush_active = flush;

  // Watchdog runs only while reads are in flight and nothing comes back
  always_comb begin
    wd_counting = (outstanding != '0) && !mem_valid && !flush;
    wd_expire   = wd_counting && (wd_count == WD_W'(TIMEOUT_CYCLES - 1));
  end

  // Watchdog counter, restarted by every return and by idle periods
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_count <= '0;
    end else if (wd_counting && !wd_expire) begin
      wd_count <= wd_count + WD_W'(1);
    end else begin
      wd_count <= '0;
    end
  end
`else
  assign flush_active = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Burst sequencing: issue side, return side, pending slot and sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      burst_len       <= '0;
      issued          <= '0;
      received        <= '0;
      outstanding     <= '0;
      pending_valid   <= 1'b0;
      pending_address <= '0;
      pending_length  <= '0;
      overrun         <= 1'b0;
      rd_available    <= 1'b0;
      rd_data         <= '0;
      mem_rd_request  <= 1'b0;
      mem_address     <= '0;
`ifdef SDRAM_BURST_TIMEOUT_EN
      flush           <= 1'b0;
      timeout         <= 1'b0;
`endif
    end else begin
      rd_available <= ret;
      if (ret) begin
        rd_data  <= mem_data;
        received <= received + BURST_WIDTH'(1);
      end
      outstanding <= outstanding_next;
      issued      <= issued_next;
      if (accept) begin
        mem_address <= mem_address + ADDR_WIDTH'(1);
      end

      mem_rd_request <= 1'b0;
      case (state)
        IDLE: begin
        end
        ISSUE: begin
          mem_rd_request <= (issued_next != burst_len) && (outstanding_next < OUT_MAX);
          if (issued_next == burst_len) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (burst_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (start_pending) begin
        pending_valid <= 1'b0;
      end

      if (launch) begin
        state          <= ISSUE;
        burst_len      <= launch_length;
        issued         <= '0;
        received       <= '0;
        mem_address    <= launch_address;
        mem_rd_request <= 1'b1;
      end

      if (req_ok && !start_request) begin
        if (pending_valid && (state != IDLE)) begin
          overrun <= 1'b1;
        end else begin
          pending_valid   <= 1'b1;
          pending_address <= rd_address;
          pending_length  <= rd_burst_length;
        end
      end

`ifdef SDRAM_BURST_TIMEOUT_EN
      if (flush) begin
        outstanding <= '0;
        if (received != burst_len) begin
          rd_available <= 1'b1;
          rd_data      <= '0;
          received     <= received + BURST_WIDTH'(1);
        end else begin
          flush <= 1'b0;
        end
      end else if (wd_expire) begin
        flush          <= 1'b1;
        timeout        <= 1'b1;
        state          <= DRAIN;
        mem_rd_request <= 1'b0;
        outstanding    <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// tb_sdram_burst_responder
// Directed bench for sdram_burst_responder with a latency-programmable memory
// model and an in-order scoreboard of expected addresses and words.
// Define SDRAM_BURST_TIMEOUT_EN for the watchdog scenario as well.
module tb_sdram_burst_responder;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int BW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_request = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic [BW-1:0] rd_burst_length = '0;
  logic          rd_available;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          overrun;
  logic          timeout;
  logic          mem_rd_request;
  logic [AW-1:0] mem_address;
  logic          mem_ready = 1'b1;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_data = '0;

  int vectors = 0;
  int miscompares = 0;

  int  cyc = 0;
  int  latency = 3;
  bit  mem_enable = 1'b1;
  bit  monitor_on = 1'b1;
  int  tb_out = 0;
  int  max_out = 0;
  int  words_rx = 0;
  bit  exp_avail = 1'b0;
  bit  m_acc;
  bit  m_ret;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            mem_due_q[$];
  logic [DW-1:0] mem_dat_q[$];

  sdram_burst_responder dut (
    .clk             (clk),
    .reset           (reset),
    .rd_request      (rd_request),
    .rd_address      (rd_address),
    .rd_burst_length (rd_burst_length),
    .rd_available    (rd_available),
    .rd_data         (rd_data),
    .busy            (busy),
    .overrun         (overrun),
    .timeout         (timeout),
    .mem_rd_request  (mem_rd_request),
    .mem_address     (mem_address),
    .mem_ready       (mem_ready),
    .mem_valid       (mem_valid),
    .mem_data        (mem_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] dataOf(input logic [AW-1:0] a);
    return {a[7:0], 1'b1, a};
  endfunction

  // Memory model and scoreboard: checks outputs, then drives the next return
  always @(negedge clk) begin
    cyc++;
    if (monitor_on) begin
      if (rd_available || exp_avail) checkOutput("rd_available", rd_available, exp_avail);
      if (rd_available) begin
        words_rx++;
        if (exp_data_q.size() == 0) checkOutput("rd_data_extra", 1, 0);
        else checkOutput("rd_data", rd_data, exp_data_q.pop_front());
      end
    end
    m_acc = reset && mem_rd_request && mem_ready;
    if (m_acc) begin
      if (exp_addr_q.size() == 0) checkOutput("mem_addr_extra", 1, 0);
      else checkOutput("mem_address", mem_address, exp_addr_q.pop_front());
      if (mem_enable) begin
        mem_due_q.push_back(cyc + latency);
        mem_dat_q.push_back(dataOf(mem_address));
      end
    end
    mem_valid = 1'b0;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      mem_valid = 1'b1;
      mem_data  = mem_dat_q.pop_front();
      void'(mem_due_q.pop_front());
    end
    m_ret = mem_valid && (tb_out > 0) && reset;
    if (!reset) tb_out = 0;
    else tb_out = tb_out + int'(m_acc) - int'(m_ret);
    if (tb_out > max_out) max_out = tb_out;
    exp_avail = m_ret;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [BW-1:0] len, input bit expect_run);
    logic [AW-1:0] w;
    rd_request      = 1'b1;
    rd_address      = a;
    rd_burst_length = len;
    if (expect_run) begin
      for (int i = 0; i < int'(len); i++) begin
        w = a + AW'(i);
        exp_addr_q.push_back(w);
        exp_data_q.push_back(dataOf(w));
      end
    end
    step();
    rd_request = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while ((busy || exp_data_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checkOutput(tag, 64'(n < budget), 1);
  endtask

  initial begin
    bit saw_issue;
    bit saw_busy;
    int n;

    step();
    step();
    checkOutput("reset_state",
                {rd_available, rd_data, busy, overrun, timeout, mem_rd_request, mem_address}, 0);
    reset = 1'b1;
    step();

    // 1: basic burst, latency 3
    latency  = 3;
    words_rx = 0;
    applyStimulus(23'h000100, 9'd4, 1'b1);
    checkOutput("t1_issue", mem_rd_request, 1);
    checkOutput("t1_addr", mem_address, 23'h000100);
    checkOutput("t1_busy", busy, 1);
    waitIdle("t1_done", 50);
    checkOutput("t1_words", words_rx, 4);

    // 2: address wrap at the top of the space
    words_rx = 0;
    applyStimulus(23'h7FFFFE, 9'd4, 1'b1);
    checkOutput("t2_addr", mem_address, 23'h7FFFFE);
    waitIdle("t2_done", 50);
    checkOutput("t2_words", words_rx, 4);
    checkOutput("t2_addrs_left", exp_addr_q.size(), 0);

    // 3: long burst with long latency saturates the outstanding window
    latency  = 20;
    max_out  = 0;
    words_rx = 0;
    applyStimulus(23'h001000, 9'd88, 1'b1);
    waitIdle("t3_done", 400);
    checkOutput("t3_words", words_rx, 88);
    checkOutput("t3_max_outstanding", max_out, 8);

    // 4: zero-length request is a no-op
    latency   = 3;
    words_rx  = 0;
    applyStimulus(23'h002000, 9'd0, 1'b0);
    saw_issue = mem_rd_request;
    saw_busy  = busy;
    for (int i = 0; i < 6; i++) begin
      step();
      saw_issue |= mem_rd_request;
      saw_busy  |= busy;
    end
    checkOutput("t4_issue", saw_issue, 0);
    checkOutput("t4_busy", saw_busy, 0);
    checkOutput("t4_words", words_rx, 0);

    // 5: two requests during a burst, second one is dropped
    checkOutput("t5_overrun_before", overrun, 0);
    words_rx = 0;
    applyStimulus(23'h000200, 9'd8, 1'b1);
    step();
    applyStimulus(23'h000300, 9'd2, 1'b1);
    applyStimulus(23'h000400, 9'd3, 1'b0);
    checkOutput("t5_overrun", overrun, 1);
    waitIdle("t5_done", 100);
    checkOutput("t5_words", words_rx, 10);
    checkOutput("t5_addrs_left", exp_addr_q.size(), 0);

    // 6: reset mid-burst, then stale returns must be discarded
    latency = 6;
    applyStimulus(23'h000500, 9'd8, 1'b1);
    step();
    step();
    step();
    reset = 1'b0;
    step();
    checkOutput("t6_reset_outputs",
                {rd_available, rd_data, busy, overrun, timeout, mem_rd_request, mem_address}, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    step();
    reset    = 1'b1;
    words_rx = 0;
    for (int i = 0; i < 30; i++) step();
    checkOutput("t6_stale_words", words_rx, 0);
    checkOutput("t6_overrun", overrun, 0);
    checkOutput("t6_busy", busy, 0);
    applyStimulus(23'h000600, 9'd2, 1'b1);
    waitIdle("t6_recover_done", 50);
    checkOutput("t6_recover_words", words_rx, 2);

`ifdef SDRAM_BURST_TIMEOUT_EN
    // 7: memory never answers, watchdog flushes three zero words
    monitor_on = 1'b0;
    mem_enable = 1'b0;
    applyStimulus(23'h000700, 9'd3, 1'b1);
    n = 0;
    while (!rd_available && n < 1200) begin
      step();
      n++;
    end
    checkOutput("t7_latency", 64'((n >= 1020) && (n <= 1035)), 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t7_word_avail", rd_available, 1);
      checkOutput("t7_word_zero", rd_data, 0);
      step();
    end
    checkOutput("t7_after_avail", rd_available, 0);
    checkOutput("t7_after_busy", busy, 0);
    checkOutput("t7_timeout", timeout, 1);
    exp_data_q.delete();
`else
    checkOutput("timeout_tied", timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
